// File: rtl/mm_pkg.sv
// Shared definitions for the systolic matrix-multiply sequencer.
// Holds the controller state encoding, default element widths and a small
// index-width helper that never returns zero.
package mm_pkg;

    localparam int MM_DW = 8;
    localparam int MM_CW = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        WAIT   = 3'd4,
        RESULT = 3'd5
    } mm_state_e;

    // Width of an index able to address n entries; a 1-entry space still
    // gets a 1-bit index so port declarations stay legal.
    function automatic int mm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_opbuf.sv
// Operand buffer: M x M register file of DW-bit elements.
// One element write port (out-of-range coordinates simply match no element
// and are dropped). One combinational read port returning either column
// i_rd_idx (RD_COL=1, element i = mem[i][idx]) or row i_rd_idx (RD_COL=0,
// element j = mem[idx][j]). Contents clear only on reset.
module mm_opbuf
    import mm_pkg::*;
#(
    parameter int M      = 3,
    parameter int DW     = MM_DW,
    parameter int IW     = 2,
    parameter int KW     = 3,
    parameter bit RD_COL = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wr_en,
    input  logic [IW-1:0]   i_wr_row,
    input  logic [IW-1:0]   i_wr_col,
    input  logic [DW-1:0]   i_wr_data,
    input  logic [KW-1:0]   i_rd_idx,
    output logic [M*DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [M][M];

    // Element write; the address compare also filters row/col >= M.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (i_wr_en) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    if (i_wr_row == IW'(r) && i_wr_col == IW'(c)) begin
                        r_mem[r][c] <= i_wr_data;
                    end
                end
            end
        end
    end

    // Read port: one mux per output lane, selecting along column or row.
    for (genvar gi = 0; gi < M; gi++) begin : g_rd
        logic [DW-1:0] w_sel;

        // Select lane gi of column/row i_rd_idx.
        always_comb begin
            w_sel = '0;
            for (int r = 0; r < M; r++) begin
                if (i_rd_idx == KW'(r)) begin
                    w_sel = RD_COL ? r_mem[gi][r] : r_mem[r][gi];
                end
            end
        end

        assign o_rd_data[gi*DW +: DW] = w_sel;
    end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencing controller for the M x M systolic matrix-multiply array.
// Buffers A and B from a host port, then on start: clears the array,
// streams M operand beats, flushes the skew with 2M-2 zero beats, waits for
// the array result and hands it to the consumer via valid/ready.
// Registered outputs are computed from the next state so they line up with
// the state they belong to. arr_rdy_out, ld_rdy and done decode the current
// state. Optional busy-cycle counter: define MM_SEQ_PERF_EN.
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int M  = 3,
    parameter int DW = MM_DW,
    parameter int CW = MM_CW
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   ld_vld,
    output logic                   ld_rdy,
    input  logic                   ld_sel,
    input  logic [mm_idx_w(M)-1:0] ld_row,
    input  logic [mm_idx_w(M)-1:0] ld_col,
    input  logic [DW-1:0]          ld_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   arr_clr,
    output logic [M*DW-1:0]        arr_a,
    output logic [M*DW-1:0]        arr_b,
    output logic                   arr_vld_in,
    input  logic                   arr_rdy_in,
    input  logic                   arr_vld_out,
    output logic                   arr_rdy_out,
    output logic                   res_vld,
    input  logic                   res_rdy,
    output logic                   done,
    output logic [31:0]            perf_cycles
);

    localparam int IW = mm_idx_w(M);
    localparam int KW = mm_idx_w(2 * M);

    // Results come straight from the array, so CW only has to be wide
    // enough for a DW x DW product; reject nonsensical configurations.
    if (CW < 2 * DW) begin : g_cw_chk
        $error("mm_seq_ctrl: CW narrower than a DW x DW product");
    end

    mm_state_e       r_state;
    mm_state_e       w_state_next;
    logic [KW-1:0]   r_cnt;
    logic [KW-1:0]   w_cnt_next;
    logic            w_beat_acc;
    logic            w_ld_wr;
    logic [M*DW-1:0] w_col_a;
    logic [M*DW-1:0] w_row_b;

    logic            r_busy;
    logic            r_clr;
    logic            r_vld_in;
    logic            r_res_vld;
    logic [M*DW-1:0] r_arr_a;
    logic [M*DW-1:0] r_arr_b;

    assign w_beat_acc = r_vld_in && arr_rdy_in;
    assign w_ld_wr    = ld_vld && (r_state == IDLE);

    mm_opbuf #(
        .M(M), .DW(DW), .IW(IW), .KW(KW), .RD_COL(1'b1)
    ) u_buf_a (
        .i_clk    (CLK),
        .i_rst    (rst),
        .i_wr_en  (w_ld_wr && !ld_sel),
        .i_wr_row (ld_row),
        .i_wr_col (ld_col),
        .i_wr_data(ld_data),
        .i_rd_idx (w_cnt_next),
        .o_rd_data(w_col_a)
    );

    mm_opbuf #(
        .M(M), .DW(DW), .IW(IW), .KW(KW), .RD_COL(1'b0)
    ) u_buf_b (
        .i_clk    (CLK),
        .i_rst    (rst),
        .i_wr_en  (w_ld_wr && ld_sel),
        .i_wr_row (ld_row),
        .i_wr_col (ld_col),
        .i_wr_data(ld_data),
        .i_rd_idx (w_cnt_next),
        .o_rd_data(w_row_b)
    );

    // Next state and beat counter; the counter clears on any state change.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = CLR;
            end
            CLR: begin
                w_state_next = STREAM;
            end
            STREAM: begin
                if (w_beat_acc) begin
                    if (r_cnt == KW'(M - 1)) begin
                        w_state_next = (M > 1) ? FLUSH : WAIT;
                    end else begin
                        w_cnt_next = r_cnt + KW'(1);
                    end
                end
            end
            FLUSH: begin
                if (w_beat_acc) begin
                    if (r_cnt == KW'(2 * M - 3)) begin
                        w_state_next = WAIT;
                    end else begin
                        w_cnt_next = r_cnt + KW'(1);
                    end
                end
            end
            WAIT: begin
                if (arr_vld_out) w_state_next = RESULT;
            end
            RESULT: begin
                if (res_rdy) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_state_next != r_state) w_cnt_next = '0;
    end

    // State and counter registers.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Registered outputs decoded from the upcoming state; during a stall
    // the counter holds, so the same column/row is re-read and stays put.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_clr     <= 1'b0;
            r_vld_in  <= 1'b0;
            r_res_vld <= 1'b0;
            r_arr_a   <= '0;
            r_arr_b   <= '0;
        end else begin
            r_busy    <= (w_state_next != IDLE);
            r_clr     <= (w_state_next == CLR);
            r_vld_in  <= (w_state_next == STREAM) || (w_state_next == FLUSH);
            r_res_vld <= (w_state_next == RESULT);
            r_arr_a   <= (w_state_next == STREAM) ? w_col_a : '0;
            r_arr_b   <= (w_state_next == STREAM) ? w_row_b : '0;
        end
    end

    assign busy        = r_busy;
    assign arr_clr     = r_clr;
    assign arr_vld_in  = r_vld_in;
    assign res_vld     = r_res_vld;
    assign arr_a       = r_arr_a;
    assign arr_b       = r_arr_b;
    assign ld_rdy      = (r_state == IDLE);
    assign arr_rdy_out = (r_state == RESULT) && res_rdy;
    assign done        = (r_state == RESULT) && res_rdy;

`ifdef MM_SEQ_PERF_EN
    logic [31:0] r_perf;

    // Saturating count of cycles with busy high.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Scoreboard bench for mm_seq_ctrl (M=3). Stimulus pushes the expected
// clear cycle and operand beats (derived from a plain matrix model); a
// negedge monitor pops and compares whenever the array accepts a beat.
module tb_mm_seq_ctrl;

    localparam int M  = 3;
    localparam int DW = 8;

    logic            CLK = 1'b0;
    logic            rst = 1'b1;
    logic            ld_vld = 1'b0;
    logic            ld_rdy;
    logic            ld_sel = 1'b0;
    logic [1:0]      ld_row = '0;
    logic [1:0]      ld_col = '0;
    logic [DW-1:0]   ld_data = '0;
    logic            start = 1'b0;
    logic            busy;
    logic            arr_clr;
    logic [M*DW-1:0] arr_a;
    logic [M*DW-1:0] arr_b;
    logic            arr_vld_in;
    logic            arr_rdy_in = 1'b1;
    logic            arr_vld_out = 1'b0;
    logic            arr_rdy_out;
    logic            res_vld;
    logic            res_rdy = 1'b0;
    logic            done;
    logic [31:0]     perf_cycles;

    mm_seq_ctrl #(.M(M), .DW(DW), .CW(16)) dut (
        .CLK(CLK), .rst(rst),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_sel(ld_sel),
        .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
        .start(start), .busy(busy), .arr_clr(arr_clr),
        .arr_a(arr_a), .arr_b(arr_b),
        .arr_vld_in(arr_vld_in), .arr_rdy_in(arr_rdy_in),
        .arr_vld_out(arr_vld_out), .arr_rdy_out(arr_rdy_out),
        .res_vld(res_vld), .res_rdy(res_rdy), .done(done),
        .perf_cycles(perf_cycles)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [M*DW-1:0] a;
        logic [M*DW-1:0] b;
        int              cyc;
    } beat_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [7:0]  ma [M][M];
    logic [7:0]  mb [M][M];
    beat_t       exp_q [$];
    int          clr_q [$];
    int          exp_done = 0;
    int          done_cnt = 0;
    int          vld_cnt = 0;
    int          busy_cnt = 0;
    bit          stall_vld = 0;
    logic [M*DW-1:0] held_a, held_b;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one line per accepted beat, scoreboard compare.
    always @(negedge CLK) begin
        if (rst) begin
            stall_vld = 0;
            busy_cnt  = 0;
        end else begin
            if (busy) busy_cnt++;
            if (arr_vld_in) vld_cnt++;
            if (done) done_cnt++;
            if (arr_clr) begin
                if (clr_q.size() == 0) begin
                    check("unexpected_clr", 1, 0);
                end else begin
                    int c;
                    c = clr_q.pop_front();
                    check("clr_cycle", cyc, c);
                end
            end
            if (stall_vld) begin
                check("bp_hold_vld", arr_vld_in, 1);
                check("bp_hold_a", arr_a, held_a);
                check("bp_hold_b", arr_b, held_b);
            end
            stall_vld = arr_vld_in && !arr_rdy_in;
            held_a = arr_a;
            held_b = arr_b;
            if (arr_vld_in && arr_rdy_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    $display("beat cyc=%0d a=%06h b=%06h exp_a=%06h exp_b=%06h",
                             cyc, arr_a, arr_b, e.a, e.b);
                    check("beat_a", arr_a, e.a);
                    check("beat_b", arr_b, e.b);
                    if (e.cyc >= 0) check("beat_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Expected run from the matrix model: column k of A, row k of B, then zeros.
    task automatic push_expected(input int t0, input bit timed);
        beat_t e;
        clr_q.push_back(t0);
        for (int k = 0; k < M; k++) begin
            e.a = '0;
            e.b = '0;
            for (int i = 0; i < M; i++) begin
                e.a[i*DW +: DW] = ma[i][k];
                e.b[i*DW +: DW] = mb[k][i];
            end
            e.cyc = timed ? t0 + 1 + k : -1;
            exp_q.push_back(e);
        end
        for (int f = 0; f < 2*M-2; f++) begin
            e.a = '0;
            e.b = '0;
            e.cyc = timed ? t0 + 1 + M + f : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic load(input bit sel, input int r, input int c, input int d);
        @(posedge CLK); #1;
        ld_vld = 1; ld_sel = sel; ld_row = 2'(r); ld_col = 2'(c); ld_data = 8'(d);
        check("ld_rdy_idle", ld_rdy, 1);
        if (r < M && c < M) begin
            if (sel) mb[r][c] = 8'(d);
            else     ma[r][c] = 8'(d);
        end
        @(posedge CLK); #1;
        ld_vld = 0;
    endtask

    // One multiply. bp: 0 none, 1 random, 2 three-cycle stall on beat 1.
    task automatic run(input int bp, input bit ign, input bit rst_mid, input bit wr_with_start);
        int t0;
        int v0;
        int n;
        logic [M*DW-1:0] col1;
        @(posedge CLK); #1;
        start = 1;
        if (wr_with_start) begin
            ld_vld = 1; ld_sel = 0; ld_row = 2'd2; ld_col = 2'd2;
            ld_data = 8'($urandom_range(1, 255));
            ma[2][2] = ld_data;
        end
        @(posedge CLK); #1;
        start = 0; ld_vld = 0;
        t0 = cyc;
        push_expected(t0, bp == 0);
        v0 = vld_cnt;
        check("busy_after_start", busy, 1);
        check("ld_rdy_busy", ld_rdy, 0);
        for (int i = 0; i < M; i++) col1[i*DW +: DW] = ma[i][1];
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge CLK); #1;
            n++;
            case (bp)
                1:       arr_rdy_in = ($urandom_range(0, 3) != 0);
                2:       arr_rdy_in = !(cyc >= t0 + 2 && cyc < t0 + 5);
                default: arr_rdy_in = 1;
            endcase
            if (bp == 2 && !arr_rdy_in) check("bp_arr_a_col1", arr_a, col1);
            if (ign && cyc == t0 + 2) begin
                start = 1; ld_vld = 1; ld_sel = 0; ld_row = 0; ld_col = 0; ld_data = 8'hEE;
                check("ld_rdy_stream", ld_rdy, 0);
            end
            if (ign && cyc == t0 + 3) begin
                start = 0; ld_vld = 0;
            end
            if (rst_mid && cyc == t0 + 5) begin
                rst = 1; #1;
                check("rst_busy", busy, 0);
                check("rst_vld_in", arr_vld_in, 0);
                check("rst_clr", arr_clr, 0);
                check("rst_res_vld", res_vld, 0);
                check("rst_done", done, 0);
                check("rst_arr_a", arr_a, 0);
                check("rst_arr_b", arr_b, 0);
                check("rst_perf", perf_cycles, 0);
                foreach (ma[i, j]) begin ma[i][j] = '0; mb[i][j] = '0; end
                exp_q.delete();
                clr_q.delete();
                arr_rdy_in = 1;
                repeat (2) @(posedge CLK);
                #1 rst = 0;
                @(posedge CLK); #1;
                check("post_rst_ld_rdy", ld_rdy, 1);
                check("post_rst_busy", busy, 0);
                return;
            end
        end
        arr_rdy_in = 1;
        check("stream_timeout", exp_q.size(), 0);
        if (bp == 0) check("vld_high_cycles", vld_cnt - v0, 2*M + M - 2);
        if (bp == 2) check("vld_high_cycles_bp", vld_cnt - v0, 2*M + M - 2 + 3);
        repeat (3) begin
            @(posedge CLK); #1;
            check("wait_vld_in", arr_vld_in, 0);
            check("wait_busy", busy, 1);
            check("wait_res_vld", res_vld, 0);
        end
        arr_vld_out = 1;
        @(posedge CLK); #1;
        arr_vld_out = 0;
        repeat (2) begin
            check("res_vld_hold", res_vld, 1);
            check("arr_rdy_out_lo", arr_rdy_out, 0);
            check("done_lo", done, 0);
            @(posedge CLK); #1;
        end
        res_rdy = 1; #1;
        check("done_pulse", done, 1);
        check("arr_rdy_out_hi", arr_rdy_out, 1);
        exp_done++;
        @(posedge CLK); #1;
        res_rdy = 0;
        check("idle_busy", busy, 0);
        check("idle_res_vld", res_vld, 0);
        check("idle_ld_rdy", ld_rdy, 1);
        check("idle_done", done, 0);
`ifdef MM_SEQ_PERF_EN
        check("perf_cycles", perf_cycles, busy_cnt);
`else
        check("perf_tied", perf_cycles, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (ma[i, j]) begin ma[i][j] = '0; mb[i][j] = '0; end
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", busy, 0);
        check("reset_clr", arr_clr, 0);
        check("reset_vld_in", arr_vld_in, 0);
        check("reset_res_vld", res_vld, 0);
        check("reset_done", done, 0);
        check("reset_rdy_out", arr_rdy_out, 0);
        check("reset_arr_a", arr_a, 0);
        check("reset_arr_b", arr_b, 0);
        check("reset_perf", perf_cycles, 0);
        rst = 0;
        @(posedge CLK); #1;
        check("reset_ld_rdy", ld_rdy, 1);

        // Fresh buffers stream zeros.
        run(0, 0, 0, 0);

        // Directed A = 1..9, B = identity, plus dropped out-of-range writes.
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                load(0, r, c, r*M + c + 1);
                load(1, r, c, (r == c) ? 1 : 0);
            end
        load(0, 3, 0, 99);
        load(1, 1, 3, 77);
        run(0, 0, 0, 0);
        run(2, 0, 0, 0);
        run(0, 1, 0, 0);

        // Randomized matrices, random backpressure, write landing with start.
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < M; c++) begin
                    load(0, r, c, $urandom_range(0, 255));
                    load(1, r, c, $urandom_range(0, 255));
                end
            load($urandom_range(0, 1), 3, $urandom_range(0, 3), $urandom_range(0, 255));
            run(1, 0, 0, it[0]);
        end

        // Reset in FLUSH, then confirm buffers stream zeros.
        run(0, 0, 1, 0);
        run(0, 0, 0, 0);

        check("done_count", done_cnt, exp_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm_seq_ctrl.md
# mm_seq_ctrl

Sequencing controller for the M×M weight-stationary-free systolic matrix-multiply datapath (`main`: feeds plus `sys_arr`). It does the following:
- Buffers operand matrices A and B written element-by-element from a host port.
- On `start`, clears the array accumulators and streams one A column and one B row per accepted beat.
- Flushes the skewed pipeline with zero beats, then hands the array's 16-bit result matrix to the consumer through a valid/ready handshake.

## Interface
- `M`, 3: matrix dimension.
- `DW`, 8: operand element width.
- `CW`, 16: result element width. Informational; results pass straight from the array.
- `CLK` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ld_vld` in 1: host element write valid.
- `ld_rdy` out 1: high in IDLE only.
- `ld_sel` in 1: 0 selects A, 1 selects B.
- `ld_row` in $clog2(M): element row index.
- `ld_col` in $clog2(M): element column index.
- `ld_data` in DW: element value.
- `start` in 1: begin a multiply. Sampled in IDLE only.
- `busy` out 1: high in every state except IDLE.
- `arr_clr` out 1: one-cycle accumulator clear to the array.
- `arr_a` out DW×M: `arr_a[i]` = A[i][k].
- `arr_b` out DW×M: `arr_b[j]` = B[k][j].
- `arr_vld_in` out 1: beat valid to the array.
- `arr_rdy_in` in 1: array accepts a beat.
- `arr_vld_out` in 1: array result valid.
- `arr_rdy_out` out 1: result ready to the array.
- `res_vld` out 1: result valid to the consumer.
- `res_rdy` in 1: consumer ready.
- `done` out 1: one-cycle pulse on result handoff.
- `perf_cycles` out 32: busy-cycle count. See Configuration.

## Operation
- States: IDLE → CLR → STREAM → FLUSH → WAIT → RESULT → IDLE.
- IDLE:
  - `ld_vld` writes `ld_data` into the buffer selected by `ld_sel` at [row][col].
  - Writes with row ≥ M or col ≥ M are dropped, still acknowledged.
  - `start`=1 → CLR. If `start` and `ld_vld` arrive in the same cycle, the write lands first and is included in the run.
- CLR: `arr_clr`=1 for exactly one cycle, then STREAM with k=0.
- STREAM: drives column k of A and row k of B with `arr_vld_in`=1. k advances only when `arr_vld_in && arr_rdy_in`. After beat k=M-1 is accepted → FLUSH.
- FLUSH:
  - Drives all-zero `arr_a`/`arr_b` with `arr_vld_in`=1 for 2M-2 accepted beats, then → WAIT.
  - For M=1 FLUSH is skipped (STREAM → WAIT).
- WAIT: `arr_vld_in`=0. Stays until `arr_vld_out`=1 → RESULT. No timeout.
- RESULT:
  - `res_vld`=1 and `arr_rdy_out` = `res_rdy` (combinational pass-through).
  - On `res_vld && res_rdy`: `done`=1 that cycle, next state IDLE.
- `start` outside IDLE is ignored.
- `ld_vld` outside IDLE is not accepted (`ld_rdy`=0) and writes nothing.
- Buffers hold their contents across runs. Only reset clears them.
- Beat counter width $clog2(2M). Counter is reused by STREAM and FLUSH and cleared on every state change.

## Timing
- Reset values:
  - State IDLE; both buffers all zero; k=0; `perf_cycles`=0.
  - `busy`, `arr_clr`, `arr_vld_in`, `res_vld`, `done`, `arr_rdy_out` = 0.
  - `arr_a`/`arr_b` = 0.
  - `ld_rdy`=1 once reset deasserts.
- All outputs are registered except `arr_rdy_out`, `ld_rdy` and `done`, which are decoded from the current state.
- With `start` sampled at edge t and `arr_rdy_in` held at 1:
  - CLR during cycle t+1.
  - STREAM beats during cycles t+2 … t+M+1.
  - FLUSH during cycles t+M+2 … t+3M-1.
  - WAIT from cycle t+3M.
- Backpressure: while `arr_rdy_in`=0, `arr_a`/`arr_b`/`arr_vld_in` hold stable and k does not advance.
- `rst` asserted mid-run: immediate return to IDLE with every output at its reset value and buffers cleared. No `done` is produced.

## Configuration
- `MM_SEQ_PERF_EN` defined:
  - `perf_cycles` increments by 1 on every cycle with `busy`=1.
  - It saturates at 2^32-1 and clears only on reset.
- `MM_SEQ_PERF_EN` undefined: the port still exists and is tied to 0; no counter logic is generated.

## Structure
- Shared package `mm_pkg`:
  - `mm_state_e` enum (IDLE, CLR, STREAM, FLUSH, WAIT, RESULT).
  - Default constants `MM_DW`=8 and `MM_CW`=16.
- Sub-module `mm_opbuf`, instantiated twice (A and B):
  - M×M DW register file with one element write port.
  - One read port returns either column k or row k, selected by a parameter.
- The FSM, beat counter and perf counter live in `mm_seq_ctrl`.

## Test plan
All scenarios use M=3.
- Reset then idle: all outputs 0 except `ld_rdy`=1; a read of either buffer through a run streams zeros.
- Load A=[[1,2,3],[4,5,6],[7,8,9]] and B=identity, `start`, `arr_rdy_in`=1:
  - `arr_clr` high exactly at t+1.
  - Beats at t+2..t+4 carry `arr_a`={1,4,7},{2,5,8},{3,6,9} and `arr_b`={1,0,0},{0,1,0},{0,0,1}.
  - Four zero beats follow at t+5..t+8.
- Backpressure: drop `arr_rdy_in` on the second STREAM beat for 3 cycles → `arr_a` holds {2,5,8}, k holds, and the total `arr_vld_in` high time is 10 cycles.
- Result handshake:
  - Pulse `arr_vld_out`, hold `res_rdy`=0 for 2 cycles → `res_vld` stays 1 and `arr_rdy_out`=0.
  - Raise `res_rdy` → `done` pulses once and state returns to IDLE.
- Illegal and ignored inputs: `ld_vld` with row=3 writes nothing; `start` and `ld_vld` during STREAM are ignored and `ld_rdy`=0.
- Reset mid-FLUSH → outputs are 0 next sample, both buffers are zero, and no `done` occurs. With `MM_SEQ_PERF_EN` defined, `perf_cycles` counts 1 per busy cycle across a full run and resets to 0.
